// File: rtl/alu_serial_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_serial_seq
//  Description : Bit-serial sequencer for a 1-bit ALU slice. Latches two
//                operands and slice controls, then feeds the slice one bit
//                per clock (LSB first). It chains the carry through a
//                register, assembles the result and flags, and pulses DONE.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_serial_seq #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] OPA,
   input  logic [WIDTH-1:0] OPB,
   input  logic             ENA_IN,
   input  logic             ENB_IN,
   input  logic             INVA_IN,
   input  logic [1:0]       F_IN,
   input  logic             INC,
   input  logic             ALU_OUT,
   input  logic             ALU_COUT,
   output logic             ALU_A,
   output logic             ALU_B,
   output logic             ALU_ENA,
   output logic             ALU_ENB,
   output logic             ALU_INVA,
   output logic             ALU_F0,
   output logic             ALU_F1,
   output logic             ALU_CIN,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] RESULT,
   output logic             COUT,
   output logic             ZERO,
   output logic             NEG
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

   // Counter value during the cycle that processes the MSB
   localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

   state_t             state_q,  state_d;
   logic [WIDTH-1:0]   sha_q,    sha_d;
   logic [WIDTH-1:0]   shb_q,    shb_d;
   logic               ena_q,    ena_d;
   logic               enb_q,    enb_d;
   logic               inva_q,   inva_d;
   logic [1:0]         f_q,      f_d;
   logic               carry_q,  carry_d;
   logic [CNT_W-1:0]   cnt_q,    cnt_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               cout_q,   cout_d;
   logic               zero_q,   zero_d;
   logic               neg_q,    neg_d;

   logic               w_run;

   // State and datapath registers, synchronous reset to all-zero / IDLE
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         sha_q    <= '0;
         shb_q    <= '0;
         ena_q    <= 1'b0;
         enb_q    <= 1'b0;
         inva_q   <= 1'b0;
         f_q      <= 2'b00;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         zero_q   <= 1'b0;
         neg_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sha_q    <= sha_d;
         shb_q    <= shb_d;
         ena_q    <= ena_d;
         enb_q    <= enb_d;
         inva_q   <= inva_d;
         f_q      <= f_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         zero_q   <= zero_d;
         neg_q    <= neg_d;
      end
   end

   // Next-state logic: capture in IDLE, shift one bit per RUN cycle, one FIN cycle
   always_comb begin
      state_d  = state_q;
      sha_d    = sha_q;
      shb_d    = shb_q;
      ena_d    = ena_q;
      enb_d    = enb_q;
      inva_d   = inva_q;
      f_d      = f_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      cout_d   = cout_q;
      zero_d   = zero_q;
      neg_d    = neg_q;

      case (state_q)
         ST_IDLE: begin
            if (START) begin
               sha_d    = OPA;
               shb_d    = OPB;
               ena_d    = ENA_IN;
               enb_d    = ENB_IN;
               inva_d   = INVA_IN;
               f_d      = F_IN;
               carry_d  = INC;
               cnt_d    = '0;
               result_d = '0;
               cout_d   = 1'b0;
               zero_d   = 1'b0;
               neg_d    = 1'b0;
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            result_d = {ALU_OUT, result_q[WIDTH-1:1]};
            sha_d    = sha_q >> 1;
            shb_d    = shb_q >> 1;
            carry_d  = ALU_COUT;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == C_LAST_BIT) begin
               // Flags are taken from the completed result so they are
               // already valid in the cycle that DONE is high.
               cout_d  = ALU_COUT;
               zero_d  = (result_d == '0);
               neg_d   = ALU_OUT;
               state_d = ST_FIN;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Slice drive is forced to zero outside RUN (AND mode, output 0)
   always_comb begin
      w_run    = (state_q == ST_RUN);
      ALU_A    = w_run & sha_q[0];
      ALU_B    = w_run & shb_q[0];
      ALU_CIN  = w_run & carry_q;
      ALU_ENA  = w_run & ena_q;
      ALU_ENB  = w_run & enb_q;
      ALU_INVA = w_run & inva_q;
      ALU_F0   = w_run & f_q[0];
      ALU_F1   = w_run & f_q[1];
      BUSY     = w_run;
      DONE     = (state_q == ST_FIN);
      RESULT   = result_q;
      COUT     = cout_q;
      ZERO     = zero_q;
      NEG      = neg_q;
   end

endmodule
`default_nettype wire

// File: doc/alu_serial_seq.md
Name: alu_serial_seq

Overview:
- Bit-serial sequencer directly upstream of the 1-bit ALU slice; it also consumes the slice's outputs.
- Per operation: latches two WIDTH-bit operands and an opcode, then drives the slice one bit per clock, LSB first, starting at bit 0.
- Carries the slice's carry-out into the next bit through a register.
- Assembles the WIDTH-bit result plus carry/zero/negative flags, then pulses DONE.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2).
- CNT_W, 4, counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  synchronous reset, active-high.
- START  in  1  request; sampled only in IDLE.
- OPA  in  WIDTH  operand A.
- OPB  in  WIDTH  operand B.
- ENA_IN  in  1  enable A, latched at START.
- ENB_IN  in  1  enable B, latched at START.
- INVA_IN  in  1  invert A, latched at START.
- F_IN  in  2  function {F1,F0}, latched at START: 00 AND, 01 OR, 10 NOT B, 11 ADD.
- INC  in  1  carry-in to bit 0, latched at START.
- ALU_OUT  in  1  slice result bit.
- ALU_COUT  in  1  slice carry-out.
- ALU_A  out  1  current bit of A to slice.
- ALU_B  out  1  current bit of B to slice.
- ALU_ENA  out  1  A enable to slice.
- ALU_ENB  out  1  B enable to slice.
- ALU_INVA  out  1  A invert to slice.
- ALU_F0  out  1  function bit 0 to slice.
- ALU_F1  out  1  function bit 1 to slice.
- ALU_CIN  out  1  carry-in to slice.
- BUSY  out  1  high in RUN.
- DONE  out  1  one-cycle completion pulse.
- RESULT  out  WIDTH  assembled result, held until next START.
- COUT  out  1  carry after MSB.
- ZERO  out  1  RESULT == 0.
- NEG  out  1  RESULT[WIDTH-1].

Behaviour:
- Reset values: all outputs 0; state IDLE; counter 0; carry register 0; shift registers 0.
- The slice is combinational; the sequencer is fully synchronous.
- FSM states: IDLE, RUN, FIN.
- IDLE, START=1:
  - Latch OPA→shA, OPB→shB, ENA/ENB/INVA/F, carry←INC.
  - Clear RESULT, COUT, ZERO, NEG; counter←0.
  - Go to RUN.
- IDLE, START=0: stay in IDLE.
- RUN, combinational drive:
  - ALU_A=shA[0], ALU_B=shB[0], ALU_CIN=carry.
  - ALU_ENA/ENB/INVA/F0/F1 = latched values.
- RUN, each edge:
  - RESULT ← {ALU_OUT, RESULT[WIDTH-1:1]}.
  - shA, shB shift right by 1.
  - carry ← ALU_COUT.
  - counter+1.
- RUN exit: when counter==WIDTH-1 at the edge, go to FIN. RUN lasts exactly WIDTH cycles.
- FIN, one cycle:
  - DONE=1; COUT=carry; ZERO and NEG registered from the final RESULT.
  - Next state IDLE.
- Latency: START sampled at edge 0 → DONE high during cycle WIDTH+1 (cycle 9 for WIDTH=8). Back-to-back throughput is one op per WIDTH+2 cycles.
- Logic ops: slice carry-out is 0, so COUT=0 regardless of INC.
- Outside RUN: ALU_ENA=ALU_ENB=ALU_INVA=ALU_F0=ALU_F1=ALU_A=ALU_B=ALU_CIN=0, so the slice is in AND mode with output 0.
- START while BUSY or in FIN: ignored, no queuing. OPA/OPB/control changes during RUN have no effect.
- RESULT, COUT, ZERO, NEG stay stable from FIN until the next accepted START.
- RST high in any state, including mid-RUN: next edge returns to reset values. No DONE pulse; the partial result is discarded.
- RST and START high together: RST wins; START is not captured.

Test Plan (WIDTH=8):
- ADD: A=0x5A, B=0x3C, F=11, ENA=ENB=1, INVA=0, INC=0 → RESULT=0x96, COUT=0, NEG=1, ZERO=0. DONE only in cycle 9; BUSY high cycles 1–8.
- Overflow: A=0xFF, B=0x01, ADD, INC=0 → RESULT=0x00, COUT=1, ZERO=1.
- Subtract B−A: A=0x05, B=0x10, INVA=1, INC=1, ADD → RESULT=0x0B, COUT=1.
  - Also: ENA=0, INVA=1, B=0x00, INC=0 → RESULT=0xFF, NEG=1.
- Logic ops with A=0xF0, B=0x3C, INC=1:
  - AND → 0x30.
  - OR → 0xFC.
  - NOT B → 0xC3.
  - Every case COUT=0.
- START re-asserted in cycles 3 and 9 → ignored; a second START accepted from IDLE yields a correct independent result. A back-to-back pair completes in 20 cycles.
- RST high in RUN cycle 4 → next cycle BUSY=0, RESULT=0, all ALU_* outputs 0, no DONE. A following ADD 0x01+0x01 → 0x02.
